// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and in-order load returns into one registered register-file write port.
// Latency: one cycle from accepted source to reg_wr_en; a colliding ALU result waits in a one-entry skid.
// Backpressure: alu_ready drops while the skid holds an entry; loads are never stalled.
// Optional: define WB_BYPASS_EN to expose the next-edge write on byp_valid/byp_reg/byp_data.
module wb_arbiter #(
   parameter int DATAW        = 32,
   parameter int NUMREGISTERS = 8,
   parameter int LD_DEPTH     = 4,
   localparam int RW = (NUMREGISTERS > 1) ? $clog2(NUMREGISTERS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   input  logic [RW-1:0]    alu_reg,
   input  logic [DATAW-1:0] alu_data,
   output logic             alu_ready,
   input  logic             ld_issue,
   input  logic [RW-1:0]    ld_issue_reg,
   input  logic             ld_valid,
   input  logic [DATAW-1:0] ld_data,
   output logic             ld_full,
   output logic [NUMREGISTERS-1:0] busy_mask,
   output logic             reg_wr_en,
   output logic [RW-1:0]    wr_reg,
   output logic [DATAW-1:0] wr_data,
`ifdef WB_BYPASS_EN
   output logic             byp_valid,
   output logic [RW-1:0]    byp_reg,
   output logic [DATAW-1:0] byp_data,
`endif
   output logic             wb_err
);

   localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam int CW = $clog2(LD_DEPTH + 1);

   // Tag FIFO of outstanding load destinations (circular, arbitrary depth)
   logic [RW-1:0] tag_q [LD_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // One-entry skid for ALU results that lose the write port to a load return
   logic             skid_vld;
   logic [RW-1:0]    skid_reg;
   logic [DATAW-1:0] skid_data;

   logic             alu_acc;
   logic             pop;
   logic             push;
   logic             err_full;
   logic             err_empty;
   logic             wr_en_nxt;
   logic [RW-1:0]    wr_reg_nxt;
   logic [DATAW-1:0] wr_data_nxt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(LD_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign ld_full   = (count == CW'(LD_DEPTH));
   assign alu_ready = ~skid_vld;
   assign alu_acc   = alu_valid & alu_ready;
   // A return with no queued tag has no destination, so it is dropped.
   assign pop       = ld_valid & (count != '0);
   assign err_empty = ld_valid & (count == '0);
   // A full FIFO still accepts a push when the same cycle frees the head slot.
   assign push      = ld_issue & (~ld_full | pop);
   assign err_full  = ld_issue & ld_full & ~ld_valid;

   // Busy mask: OR together the destinations of every occupied FIFO slot
   always_comb begin
      int idx;
      idx       = 0;
      busy_mask = '0;
      for (int k = 0; k < LD_DEPTH; k++) begin
         if (k < int'(count)) begin
            idx = int'(rd_ptr) + k;
            if (idx >= LD_DEPTH) idx = idx - LD_DEPTH;
            busy_mask[tag_q[PW'(idx)]] = 1'b1;
         end
      end
   end

   // Write-port selection: load return first, then skid, then a fresh ALU result
   always_comb begin
      wr_en_nxt   = 1'b0;
      wr_reg_nxt  = '0;
      wr_data_nxt = '0;
      if (pop) begin
         wr_en_nxt   = 1'b1;
         wr_reg_nxt  = tag_q[rd_ptr];
         wr_data_nxt = ld_data;
      end else if (!ld_valid && skid_vld) begin
         wr_en_nxt   = 1'b1;
         wr_reg_nxt  = skid_reg;
         wr_data_nxt = skid_data;
      end else if (!ld_valid && alu_acc) begin
         wr_en_nxt   = 1'b1;
         wr_reg_nxt  = alu_reg;
         wr_data_nxt = alu_data;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_valid = rst_n & wr_en_nxt;
   assign byp_reg   = wr_reg_nxt;
   assign byp_data  = wr_data_nxt;
`endif

   // Tag storage needs no reset: only slots counted as occupied are ever read
   always_ff @(posedge clk) begin
      if (rst_n && push) tag_q[wr_ptr] <= ld_issue_reg;
   end

   // Pointers, skid, registered write port and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         skid_vld  <= 1'b0;
         skid_reg  <= '0;
         skid_data <= '0;
         reg_wr_en <= 1'b0;
         wr_reg    <= '0;
         wr_data   <= '0;
         wb_err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);

         if (skid_vld) begin
            if (!ld_valid) skid_vld <= 1'b0;
         end else if (alu_acc && ld_valid) begin
            skid_vld  <= 1'b1;
            skid_reg  <= alu_reg;
            skid_data <= alu_data;
         end

         reg_wr_en <= wr_en_nxt;
         if (wr_en_nxt) begin
            wr_reg  <= wr_reg_nxt;
            wr_data <= wr_data_nxt;
         end

         if (err_full || err_empty) wb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based model checked every cycle plus directed literal checks.
// Inputs change 1 ns after each rising edge; model updates on the edge, comparisons run on the falling edge.
// Define WB_BYPASS_EN for both bench and design to cover the bypass outputs.
module tb_wb_arbiter;

   localparam int DATAW = 32;
   localparam int NR    = 8;
   localparam int LD    = 4;
   localparam int RW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             alu_valid;
   logic [RW-1:0]    alu_reg;
   logic [DATAW-1:0] alu_data;
   logic             alu_ready;
   logic             ld_issue;
   logic [RW-1:0]    ld_issue_reg;
   logic             ld_valid;
   logic [DATAW-1:0] ld_data;
   logic             ld_full;
   logic [NR-1:0]    busy_mask;
   logic             reg_wr_en;
   logic [RW-1:0]    wr_reg;
   logic [DATAW-1:0] wr_data;
   logic             wb_err;
`ifdef WB_BYPASS_EN
   logic             byp_valid;
   logic [RW-1:0]    byp_reg;
   logic [DATAW-1:0] byp_data;
`endif

   wb_arbiter #(.DATAW(DATAW), .NUMREGISTERS(NR), .LD_DEPTH(LD)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_issue(ld_issue), .ld_issue_reg(ld_issue_reg),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_full(ld_full), .busy_mask(busy_mask),
      .reg_wr_en(reg_wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
`ifdef WB_BYPASS_EN
      .byp_valid(byp_valid), .byp_reg(byp_reg), .byp_data(byp_data),
`endif
      .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic en; logic [RW-1:0] r; logic [DATAW-1:0] d; } wr_t;
   typedef struct { logic [RW-1:0] r; logic [DATAW-1:0] d; } ent_t;

   logic [RW-1:0] tq[$];       // outstanding load destinations, oldest first
   ent_t          sk[$];       // ALU results waiting for the write port
   logic          m_en   = 1'b0;
   logic [RW-1:0] m_reg  = '0;
   logic [DATAW-1:0] m_data = '0;
   logic          m_err  = 1'b0;
   logic          m_rst  = 1'b1;

   function automatic wr_t model_next();
      wr_t w;
      w.en = 1'b0; w.r = '0; w.d = '0;
      if (!rst_n) return w;
      if (ld_valid && tq.size() > 0) begin
         w.en = 1'b1; w.r = tq[0]; w.d = ld_data;
      end else if (!ld_valid && sk.size() > 0) begin
         w.en = 1'b1; w.r = sk[0].r; w.d = sk[0].d;
      end else if (!ld_valid && alu_valid && sk.size() == 0) begin
         w.en = 1'b1; w.r = alu_reg; w.d = alu_data;
      end
      return w;
   endfunction

   function automatic logic [NR-1:0] model_busy();
      logic [NR-1:0] b;
      b = '0;
      foreach (tq[i]) b[tq[i]] = 1'b1;
      return b;
   endfunction

   always @(posedge clk) begin
      wr_t  w;
      ent_t e;
      w = model_next();
      if (!rst_n) begin
         tq.delete(); sk.delete();
         m_en = 1'b0; m_reg = '0; m_data = '0; m_err = 1'b0; m_rst = 1'b1;
      end else begin
         m_rst = 1'b0;
         if (ld_valid && tq.size() == 0) m_err = 1'b1;
         if (ld_issue && !ld_valid && tq.size() == LD) m_err = 1'b1;
         m_en = w.en;
         if (w.en) begin m_reg = w.r; m_data = w.d; end
         if (sk.size() > 0 && !ld_valid) void'(sk.pop_front());
         else if (alu_valid && sk.size() == 0 && ld_valid) begin
            e.r = alu_reg; e.d = alu_data; sk.push_back(e);
         end
         if (ld_valid && tq.size() > 0) void'(tq.pop_front());
         if (ld_issue && tq.size() < LD) tq.push_back(ld_issue_reg);
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("m.reg_wr_en", 64'(reg_wr_en), 64'(m_en));
         if (m_en || m_rst) begin
            check("m.wr_reg", 64'(wr_reg), 64'(m_reg));
            check("m.wr_data", 64'(wr_data), 64'(m_data));
         end
         check("m.wb_err", 64'(wb_err), 64'(m_err));
         check("m.alu_ready", 64'(alu_ready), 64'(sk.size() == 0));
         check("m.ld_full", 64'(ld_full), 64'(tq.size() == LD));
         check("m.busy_mask", 64'(busy_mask), 64'(model_busy()));
`ifdef WB_BYPASS_EN
         begin
            wr_t b;
            b = model_next();
            check("m.byp_valid", 64'(byp_valid), 64'(b.en));
            if (b.en) begin
               check("m.byp_reg", 64'(byp_reg), 64'(b.r));
               check("m.byp_data", 64'(byp_data), 64'(b.d));
            end
         end
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
      ld_issue = 1'b0; ld_issue_reg = '0; ld_valid = 1'b0; ld_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [RW-1:0] r, input logic [DATAW-1:0] d);
      alu_valid = 1'b1; alu_reg = r; alu_data = d;
   endtask

   task automatic issue(input logic [RW-1:0] r);
      ld_issue = 1'b1; ld_issue_reg = r;
   endtask

   task automatic ret(input logic [DATAW-1:0] d);
      ld_valid = 1'b1; ld_data = d;
   endtask

   task automatic expect_wr(input string name, input logic [RW-1:0] r, input logic [DATAW-1:0] d);
      check({name, ".en"}, 64'(reg_wr_en), 64'd1);
      check({name, ".reg"}, 64'(wr_reg), 64'(r));
      check({name, ".data"}, 64'(wr_data), 64'(d));
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      step(); step();
      chk_en = 1'b1;
      // reset values
      check("rst.reg_wr_en", 64'(reg_wr_en), 64'd0);
      check("rst.wr_reg", 64'(wr_reg), 64'd0);
      check("rst.wr_data", 64'(wr_data), 64'd0);
      check("rst.wb_err", 64'(wb_err), 64'd0);
      check("rst.alu_ready", 64'(alu_ready), 64'd1);
      check("rst.busy", 64'(busy_mask), 64'd0);
      check("rst.ld_full", 64'(ld_full), 64'd0);
      rst_n = 1'b1;

      // ALU only
      alu(3'd3, 32'h0000_00AA);
      step(); idle();
      expect_wr("alu", 3'd3, 32'hAA);
      check("alu.ready", 64'(alu_ready), 64'd1);
      step();
      check("alu.idle", 64'(reg_wr_en), 64'd0);

`ifdef WB_BYPASS_EN
      alu(3'd6, 32'h5);
      #1;
      check("byp.valid", 64'(byp_valid), 64'd1);
      check("byp.reg", 64'(byp_reg), 64'd6);
      check("byp.data", 64'(byp_data), 64'd5);
      step(); idle();
      expect_wr("byp.wr", 3'd6, 32'h5);
`endif

      // load path
      issue(3'd5);
      step(); idle();
      check("ld.busy", 64'(busy_mask), 64'h20);
      step(); step(); step();
      ret(32'hDEAD);
      step(); idle();
      expect_wr("ld", 3'd5, 32'hDEAD);
      check("ld.busy0", 64'(busy_mask), 64'h00);

      // collision, plus an ALU offer held while the skid is busy
      issue(3'd1); step();
      issue(3'd4); step(); idle();
      ret(32'h11); alu(3'd2, 32'h22);
      step(); idle();
      expect_wr("col1", 3'd1, 32'h11);
      check("col1.ready", 64'(alu_ready), 64'd0);
      ret(32'h44); alu(3'd7, 32'h77);
      step(); idle(); alu(3'd7, 32'h77);
      expect_wr("col2", 3'd4, 32'h44);
      check("col2.ready", 64'(alu_ready), 64'd0);
      step();
      expect_wr("col3", 3'd2, 32'h22);
      check("col3.ready", 64'(alu_ready), 64'd1);
      step(); idle();
      expect_wr("col4", 3'd7, 32'h77);
      step();
      check("col.idle", 64'(reg_wr_en), 64'd0);

      // full FIFO, duplicate destinations and wrap-around
      issue(3'd1); step();
      issue(3'd2); step();
      issue(3'd1); step();
      issue(3'd3); step(); idle();
      check("full.ld_full", 64'(ld_full), 64'd1);
      check("full.busy", 64'(busy_mask), 64'h0E);
      issue(3'd6); ret(32'h101);
      step(); idle();
      expect_wr("full.cc", 3'd1, 32'h101);
      check("full.cc.busy", 64'(busy_mask), 64'h4E);
      check("full.cc.full", 64'(ld_full), 64'd1);
      check("full.cc.err", 64'(wb_err), 64'd0);
      issue(3'd7);
      step(); idle();
      check("full.drop.err", 64'(wb_err), 64'd1);
      check("full.drop.busy", 64'(busy_mask), 64'h4E);
      check("full.drop.full", 64'(ld_full), 64'd1);
      ret(32'h102); step(); idle();
      expect_wr("drain1", 3'd2, 32'h102);
      check("drain1.busy", 64'(busy_mask), 64'h4A);
      ret(32'h103); alu(3'd5, 32'h55); step(); idle();
      expect_wr("drain2", 3'd1, 32'h103);
      check("drain2.busy", 64'(busy_mask), 64'h48);
      ret(32'h104); step(); idle();
      expect_wr("drain3", 3'd3, 32'h104);
      ret(32'h105); step(); idle();
      expect_wr("drain4", 3'd6, 32'h105);
      check("drain4.busy", 64'(busy_mask), 64'h00);
      step();
      expect_wr("drain.skid", 3'd5, 32'h55);

      // empty pop and reset recovery
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("rst2.err", 64'(wb_err), 64'd0);
      ret(32'h999); step(); idle();
      check("empty.wr_en", 64'(reg_wr_en), 64'd0);
      check("empty.err", 64'(wb_err), 64'd1);
      issue(3'd2); ret(32'h888); step(); idle();
      check("empty.cc.wr_en", 64'(reg_wr_en), 64'd0);
      check("empty.cc.busy", 64'(busy_mask), 64'h04);
      ret(32'h7); alu(3'd5, 32'h50); step(); idle();
      expect_wr("pre_rst", 3'd2, 32'h7);
      check("pre_rst.ready", 64'(alu_ready), 64'd0);
      rst_n = 1'b0; alu(3'd3, 32'h33); issue(3'd4);
      step(); idle(); rst_n = 1'b1;
      check("rst3.wr_en", 64'(reg_wr_en), 64'd0);
      check("rst3.wr_reg", 64'(wr_reg), 64'd0);
      check("rst3.wr_data", 64'(wr_data), 64'd0);
      check("rst3.err", 64'(wb_err), 64'd0);
      check("rst3.ready", 64'(alu_ready), 64'd1);
      check("rst3.busy", 64'(busy_mask), 64'd0);
      check("rst3.full", 64'(ld_full), 64'd0);
      step();
      check("rst3.skid_gone", 64'(reg_wr_en), 64'd0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter at the far end of the register-file write port: it merges single-cycle ALU results and in-order load returns from memory into one registered write stream (`reg_wr_en`/`wr_reg`/`wr_data`) that feeds the decode stage's register file. It tracks outstanding load destinations in a tag FIFO and exports a busy mask, so decode can stall on load-use hazards. A one-entry skid buffer absorbs ALU results that collide with load returns.

## Interface
- `DATAW`, 32, data width
- `NUMREGISTERS`, 8, register count; register index width is clog2(NUMREGISTERS)
- `LD_DEPTH`, 4, maximum outstanding loads (tag FIFO entries)

- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`
- `alu_valid`  in  1  ALU result offered
- `alu_reg`  in  clog2(NUMREGISTERS)  ALU destination register
- `alu_data`  in  DATAW  ALU result
- `alu_ready`  out  1  result accepted when `alu_valid && alu_ready`
- `ld_issue`  in  1  load issued this cycle; reserves its destination
- `ld_issue_reg`  in  clog2(NUMREGISTERS)  load destination register
- `ld_valid`  in  1  load data returning; returns are in issue order
- `ld_data`  in  DATAW  returned load data
- `ld_full`  out  1  tag FIFO holds LD_DEPTH entries
- `busy_mask`  out  NUMREGISTERS  bit r set while any queued tag equals r
- `reg_wr_en`  out  1  register-file write strobe (registered)
- `wr_reg`  out  clog2(NUMREGISTERS)  write index (registered)
- `wr_data`  out  DATAW  write data (registered)
- `wb_err`  out  1  sticky protocol-error flag

## Operation
- Tag FIFO: a circular buffer of destination indices with a count.
  - `ld_issue` pushes `ld_issue_reg`.
  - `ld_valid` pops the head, which becomes the write index for `ld_data`.
- Write-source priority for each cycle: load return, then skid entry, then new ALU result.
- `alu_ready` = skid empty. An accepted ALU result writes next cycle when `ld_valid` is low that cycle. When `ld_valid` is high, the ALU result goes into the skid buffer.
- When the skid is full and `ld_valid` is low, the skid drains to the write port and the skid empties.
- When the skid is full and `ld_valid` is high, the skid holds and `alu_ready` stays 0.
- `busy_mask` is combinational from the valid FIFO entries. Two loads to the same register keep the bit set until both have popped.
- Boundary cases:
  - `ld_issue` with `ld_full` and `ld_valid` low: the push is dropped and `wb_err` is set.
  - `ld_issue` with `ld_full` and `ld_valid` high: the push and pop both occur and the count is unchanged.
  - `ld_valid` with the FIFO empty: ignored, no write occurs, `wb_err` is set.
  - `ld_issue` and `ld_valid` in the same cycle with the FIFO empty: the pop returns nothing, so this is an error and the push still occurs.
- `wb_err` clears only on reset.

## Timing
- Reset values:
  - `reg_wr_en`=0, `wr_reg`=0, `wr_data`=0, `wb_err`=0.
  - FIFO empty, so `ld_full`=0 and `busy_mask`=0.
  - Skid empty, so `alu_ready`=1.
- Reset mid-operation discards all queued tags and the skid entry. Any write registered for the following edge is cancelled.
- Latency:
  - Load return at cycle N writes at N+1.
  - Uncontended ALU result at N writes at N+1.
  - ALU result colliding at N writes at N+1+k, where k is the number of consecutive `ld_valid` cycles starting at N.
- `busy_mask` and `ld_full` reflect a push or pop one cycle after it, i.e. from registered state.
- Wrap-around: read and write pointers are modulo LD_DEPTH. LD_DEPTH is not required to be a power of two.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `byp_valid`, `byp_reg` and `byp_data`. Each cycle they combinationally present the write that will register at the next edge, so decode can forward a result one cycle early.
- `WB_BYPASS_EN` undefined: these ports are absent, and results are visible only through the register file after `reg_wr_en`.

## Test plan
- ALU only: `alu_valid` with r3=0x0000_00AA at cycle 5 -> `reg_wr_en`=1, `wr_reg`=3, `wr_data`=0xAA at cycle 6; `alu_ready` stays 1.
- Load path: `ld_issue` r5 at cycle 2 -> `busy_mask`=0x20 at cycle 3; `ld_valid` 0xDEAD at cycle 7 -> write r5=0xDEAD at cycle 8; `busy_mask`=0 at cycle 8.
- Collision: `ld_valid` (tag r1, 0x11) and ALU r2=0x22 at cycle 10, then `ld_valid` again at cycle 11 (tag r4) -> cycle 11 writes r1, cycle 12 writes r4, cycle 13 writes r2; `alu_ready`=0 during cycles 11-12.
- Full FIFO: issue 4 loads -> `ld_full`=1; a 5th `ld_issue` alone -> `wb_err`=1 and count stays 4; a 5th issue concurrent with `ld_valid` -> accepted, `wb_err` unaffected.
- Empty pop: `ld_valid` with no tags -> no write and `wb_err`=1; then `rst_n`=0 for one cycle -> `wb_err`=0 and all outputs at reset values.
- With `WB_BYPASS_EN`: ALU r6=0x5 at cycle N -> `byp_valid`=1, `byp_reg`=6, `byp_data`=0x5 at cycle N; the register write follows at N+1.
